adder_seq_ctrl: RTL and testbench

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// ============================================================================
// adder_seq_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Serial (nibble-at-a-time) adder. One FA4bit slice is reused for WIDTH/4
//   cycles to form {cout,sum} = a + b + cin. The operands and carry-in are
//   captured when start is accepted. Nibble k is then processed on the k-th
//   RUN edge, with the carry rippling through a register between nibbles.
//
// Optional feature:
//   ADDER_SEQ_SUB_EN - when defined, adds input 'sub'. With sub=1 the block
//                      computes a - b as a + ~b + 1, and cin is ignored.
//                      In that mode cout=1 means "no borrow".
//
// Parameters:
//   WIDTH  operand/result width, a multiple of 4 in the range 4..64 (default 16)
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      begin an operation (honoured only in IDLE or DONE)
//   a      in   WIDTH  operand A, sampled with start
//   b      in   WIDTH  operand B, sampled with start
//   cin    in   1      carry-in, sampled with start
//   sub    in   1      subtract select (only with ADDER_SEQ_SUB_EN)
//   busy   out  1      high while the nibble loop is running
//   done   out  1      one-cycle pulse when sum/cout are valid
//   sum    out  WIDTH  registered result (modulo 2^WIDTH)
//   cout   out  1      registered final carry-out
// ============================================================================

// Plain 4-bit ripple slice shared by every nibble of the serial adder.
module FA4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module adder_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB = WIDTH / 4;
    // A one-nibble build still needs a 1-bit counter to keep widths legal.
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;

    logic [WIDTH-1:0] load_b;
    logic             load_c;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       fa_sum;
    logic             fa_cout;

    // These are the values captured at start. Subtraction is folded in here
    // by storing ~b and forcing the initial carry to 1. The nibble loop
    // therefore never needs to know which operation it is running.
`ifdef ADDER_SEQ_SUB_EN
    always_comb begin
        load_b = sub ? ~b : b;
        load_c = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        load_b = b;
        load_c = cin;
    end
`endif

    // Select the current nibble of each latched operand. The comparison loop
    // keeps the mux friendly to all tools. A variable part-select would do
    // the same job, but some tools handle it less cleanly.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int k = 0; k < NIB; k++) begin
            if (cnt_q == CW'(k)) begin
                nib_a = a_q[4*k +: 4];
                nib_b = b_q[4*k +: 4];
            end
        end
    end

    FA4bit u_fa (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state logic. Each nibble sum is written only into its own slot of
    // the result register. The final slice carry becomes cout. The carry
    // out of the top bit is never folded back into sum, which gives the
    // modulo 2^WIDTH result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = load_b;
                    carry_d = load_c;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                for (int k = 0; k < NIB; k++) begin
                    if (cnt_q == CW'(k)) begin
                        sum_d[4*k +: 4] = fa_sum;
                    end
                end
                carry_d = fa_cout;
                if (cnt_q == LAST_NIB) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    cout_d  = fa_cout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers. Reset may arrive mid-operation. It clears everything,
    // including the latched operands, so the interrupted operation leaves
    // no trace and produces no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // busy and done are pure state decodes. They can never overlap, and they
    // drop the moment reset is asserted.
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// ============================================================================
// tb_adder_seq_ctrl
// ----------------------------------------------------------------------------
// Directed bench for adder_seq_ctrl at WIDTH=16.
//
// A behavioural model inside the bench tracks the expected outputs:
//   - it computes the expected {cout,sum} with plain arithmetic at start;
//   - it counts out the RUN cycles to predict busy and done.
// A negedge process compares the DUT against this model on every cycle.
// Each directed case also checks its final result against a literal value
// worked out by hand, along with the done latency and the pulse count.
// ============================================================================
module tb_adder_seq_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int cycle_cnt = 0;
    int done_pulses = 0;
    int accept_cycle = 0;

    adder_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef ADDER_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Behavioural model: an idle/busy countdown plus an arithmetic result.
    int           run_left;
    logic         done_m;
    logic [W-1:0] exp_sum, pend_sum;
    logic         exp_cout, pend_cout;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_left  <= 0;
            done_m    <= 1'b0;
            exp_sum   <= '0;
            exp_cout  <= 1'b0;
            pend_sum  <= '0;
            pend_cout <= 1'b0;
        end else if (run_left != 0) begin
            run_left <= run_left - 1;
            if (run_left == 1) begin
                done_m   <= 1'b1;
                exp_sum  <= pend_sum;
                exp_cout <= pend_cout;
            end
        end else begin
            done_m <= 1'b0;
            if (start) begin
                run_left <= NIB;
`ifdef ADDER_SEQ_SUB_EN
                if (sub)
                    {pend_cout, pend_sum} <= {1'b0, a} + {1'b0, ~b} + 17'd1;
                else
                    {pend_cout, pend_sum} <= {1'b0, a} + {1'b0, b} + {16'd0, cin};
`else
                {pend_cout, pend_sum} <= {1'b0, a} + {1'b0, b} + {16'd0, cin};
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model. sum and cout are undefined
    // during RUN, so they are only checked while the block is not busy.
    always @(negedge clk) begin
        checkOutput("busy", 64'(busy), 64'(run_left != 0));
        checkOutput("done", 64'(done), 64'(done_m));
        if (run_left == 0) begin
            checkOutput("sum",  64'(sum),  64'(exp_sum));
            checkOutput("cout", 64'(cout), 64'(exp_cout));
        end
        if (done) done_pulses++;
    end

    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vc, input logic vs);
        a     = va;
        b     = vb;
        cin   = vc;
        sub   = vs;
        start = 1'b1;
    endtask

    // Let the next rising edge accept the pending start, then drop it.
    task automatic acceptEdge();
        @(posedge clk);
        #2;
        accept_cycle = cycle_cnt;
        start = 1'b0;
    endtask

    // Wait for done, with a bound, and check the latency and the literal result.
    task automatic waitDone(input string name, input logic [W-1:0] xs, input logic xc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            checkOutput({name, "_latency"}, 64'(cycle_cnt - accept_cycle), 64'(NIB));
            checkOutput({name, "_sum"},  64'(sum),  64'(xs));
            checkOutput({name, "_cout"}, 64'(cout), 64'(xc));
            checkOutput({name, "_nobusy"}, 64'(busy), 64'd0);
        end
    endtask

    int pulses0;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #3;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_sum",  64'(sum),  64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);

        // Release reset at a negedge. A start asserted immediately must be
        // honoured on the very next rising edge.
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        acceptEdge();
        waitDone("wrap", 16'h0000, 1'b1);

        // Back-to-back: the second start is issued in the DONE cycle.
        @(negedge clk);
        applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0);
        acceptEdge();
        waitDone("b2b_first", 16'h5556, 1'b0);
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        acceptEdge();
        @(negedge clk);
        checkOutput("b2b_no_idle", 64'(busy), 64'd1);
        waitDone("b2b_second", 16'h1000, 1'b0);

        // A start during RUN cycle 2 must be ignored.
        @(negedge clk);
        pulses0 = done_pulses;
        applyStimulus(16'h00FF, 16'h0101, 1'b0, 1'b0);
        acceptEdge();
        @(negedge clk);
        @(posedge clk); #2;
        applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        @(posedge clk); #2;
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        checkOutput("ign_sum",  64'(sum),  64'h0200);
        checkOutput("ign_cout", 64'(cout), 64'd0);
        repeat (6) @(negedge clk);
        checkOutput("ign_one_pulse", 64'(done_pulses - pulses0), 64'd1);

        // Asynchronous reset in RUN cycle 2: outputs must clear at once, and
        // no done pulse may follow.
        applyStimulus(16'h7777, 16'h1111, 1'b1, 1'b0);
        acceptEdge();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_done", 64'(done), 64'd0);
        checkOutput("arst_sum",  64'(sum),  64'd0);
        checkOutput("arst_cout", 64'(cout), 64'd0);
        pulses0 = done_pulses;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("arst_no_done", 64'(done_pulses - pulses0), 64'd0);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
        acceptEdge();
        waitDone("after_rst", 16'h0002, 1'b0);

`ifdef ADDER_SEQ_SUB_EN
        // Subtraction cases.
        @(negedge clk);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
        acceptEdge();
        waitDone("sub_neg", 16'hFFFE, 1'b0);
        @(negedge clk);
        applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1);
        acceptEdge();
        waitDone("sub_pos", 16'h0002, 1'b1);
`endif

        // A few extra directed additions, with results worked out by hand.
        @(negedge clk);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
        acceptEdge();
        waitDone("top_carry", 16'h0000, 1'b1);
        @(negedge clk);
        applyStimulus(16'h0FFF, 16'h0000, 1'b1, 1'b0);
        acceptEdge();
        waitDone("ripple", 16'h1000, 1'b0);

        // Results must hold steady while idle.
        repeat (3) @(negedge clk);
        checkOutput("hold_sum", 64'(sum), 64'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
